// File: rtl/compare_swap_pipe.sv
// compare_swap_pipe: pipelined compare-and-swap element.
// Each operand is split into PARTS chunks. The chunks are compared one per stage,
// most significant chunk first, and the less-than/equal flags are carried from
// stage to stage. The final stage routes the operands into min/max order.
// Optional feature macro: COMPARE_SWAP_SIGNED_EN (two's complement comparison).
module compare_swap_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned PARTS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dinL,
    input  logic [WIDTH-1:0] dinR,
    input  logic             descend,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] doutL,
    output logic [WIDTH-1:0] doutR,
    output logic             L_smaller,
    output logic             equal,
    output logic             swapped
);

    localparam int unsigned CW = WIDTH / PARTS;

    // One compare step on chunk k. Returns {lt, eq} with the incoming flags folded in.
    function automatic logic [1:0] cmp_step(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input int unsigned      k,
        input logic             lt_in,
        input logic             eq_in
    );
        logic [CW-1:0] ca;
        logic [CW-1:0] cb;
        logic          borrow;
        ca = CW'(a >> (WIDTH - (k + 1) * CW));
        cb = CW'(b >> (WIDTH - (k + 1) * CW));
`ifdef COMPARE_SWAP_SIGNED_EN
        // Flipping the sign bit maps two's complement order onto unsigned order.
        if (k == 0) begin
            ca[CW-1] = ~ca[CW-1];
            cb[CW-1] = ~cb[CW-1];
        end
`endif
        borrow = 1'((({1'b0, ca} - {1'b0, cb}) >> CW));
        return {lt_in | (eq_in & borrow), eq_in & (ca == cb)};
    endfunction

    logic             enable_c;
    logic [WIDTH-1:0] fin_l;
    logic [WIDTH-1:0] fin_r;
    logic             fin_v;
    logic             fin_d;
    logic             fin_lt;
    logic             fin_eq;
    logic [1:0]       fin_flags_c;
    logic             swap_c;

    // Whole pipe advances together; it stalls only when a result waits at the output.
    assign enable_c = !out_valid || out_ready;
    assign in_ready = enable_c;

    generate
        if (PARTS == 1) begin : g_single
            // Single stage: the output register compares chunk 0 directly.
            assign fin_v  = in_valid;
            assign fin_l  = dinL;
            assign fin_r  = dinR;
            assign fin_d  = descend;
            assign fin_lt = 1'b0;
            assign fin_eq = 1'b1;
        end else begin : g_multi
            localparam int unsigned NS = PARTS - 1;

            logic [WIDTH-1:0] l_q  [NS];
            logic [WIDTH-1:0] r_q  [NS];
            logic             v_q  [NS];
            logic             d_q  [NS];
            logic             lt_q [NS];
            logic             eq_q [NS];
            logic [1:0]       flags_d [NS];

            // Flags produced by each intermediate stage from the previous stage's contents.
            always_comb begin
                flags_d = '{default: 2'b00};
                flags_d[0] = cmp_step(dinL, dinR, 0, 1'b0, 1'b1);
                for (int unsigned k = 1; k < NS; k++) begin
                    flags_d[k] = cmp_step(l_q[k-1], r_q[k-1], k, lt_q[k-1], eq_q[k-1]);
                end
            end

            // Intermediate stage registers; data only loads with a valid pair, bubbles pass as valid=0.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int unsigned k = 0; k < NS; k++) begin
                        v_q[k]  <= 1'b0;
                        l_q[k]  <= '0;
                        r_q[k]  <= '0;
                        d_q[k]  <= 1'b0;
                        lt_q[k] <= 1'b0;
                        eq_q[k] <= 1'b0;
                    end
                end else if (enable_c) begin
                    v_q[0] <= in_valid;
                    if (in_valid) begin
                        l_q[0]  <= dinL;
                        r_q[0]  <= dinR;
                        d_q[0]  <= descend;
                        lt_q[0] <= flags_d[0][1];
                        eq_q[0] <= flags_d[0][0];
                    end
                    for (int unsigned k = 1; k < NS; k++) begin
                        v_q[k] <= v_q[k-1];
                        if (v_q[k-1]) begin
                            l_q[k]  <= l_q[k-1];
                            r_q[k]  <= r_q[k-1];
                            d_q[k]  <= d_q[k-1];
                            lt_q[k] <= flags_d[k][1];
                            eq_q[k] <= flags_d[k][0];
                        end
                    end
                end
            end

            assign fin_v  = v_q[NS-1];
            assign fin_l  = l_q[NS-1];
            assign fin_r  = r_q[NS-1];
            assign fin_d  = d_q[NS-1];
            assign fin_lt = lt_q[NS-1];
            assign fin_eq = eq_q[NS-1];
        end
    endgenerate

    // Last chunk compare and swap decision; equal operands never swap.
    always_comb begin
        fin_flags_c = cmp_step(fin_l, fin_r, PARTS - 1, fin_lt, fin_eq);
        swap_c      = fin_d ? fin_flags_c[1] : (!fin_flags_c[1] && !fin_flags_c[0]);
    end

    // Output stage: routed operands and pre-swap flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            doutL     <= '0;
            doutR     <= '0;
            L_smaller <= 1'b0;
            equal     <= 1'b0;
            swapped   <= 1'b0;
        end else if (enable_c) begin
            out_valid <= fin_v;
            if (fin_v) begin
                doutL     <= swap_c ? fin_r : fin_l;
                doutR     <= swap_c ? fin_l : fin_r;
                L_smaller <= fin_flags_c[1];
                equal     <= fin_flags_c[0];
                swapped   <= swap_c;
            end
        end
    end

endmodule
